// File: rtl/aes_pkg.sv
// Shared AES definitions for the SubBytes / InvSubBytes engines.
// Provides state/byte geometry and the iterative-engine FSM state type.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTE_W  = 8;
  localparam int unsigned AES_NBYTES  = 16;

  // Engine control states, shared with the inverse engine.
  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_RUN  = 2'd1,
    ENG_DONE = 2'd2
  } aes_eng_state_e;

endpackage : aes_pkg

// File: rtl/sub_bytes_engine_if.sv
// Handshake bundle for the SubBytes engine.
//   in_valid/in_ready/in_state    : block input from AddRoundKey side
//   out_valid/out_ready/out_state : substituted block toward ShiftRows
//   busy                          : engine is in RUN or DONE
// slave = engine side, master = upstream/downstream side.
interface sub_bytes_engine_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] in_state;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] out_state;
  logic                   busy;

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

endinterface : sub_bytes_engine_if

// File: rtl/sbox.sv
// Forward AES S-box (FIPS-197), purely combinational.
//   selector : input byte
//   out      : S(selector)
module sbox (
  input  logic [7:0] selector,
  output logic [7:0] out
);

  // Row-major table, entry 0 in the most significant byte.
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry k sits at packed index 255-k, i.e. the bitwise complement of k.
  assign out = SBOX_TBL[~selector];

endmodule : sbox

// File: rtl/sub_bytes_engine.sv
// Iterative AES forward SubBytes engine.
// Accepts a 128-bit state, substitutes LANES bytes per clock (byte 0 = MSB
// first) and presents the full result until the downstream takes it.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of sub_bytes_engine_if (in/out handshakes, busy)
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic              clk,
  input  logic              rst,
  sub_bytes_engine_if.slave bus
);

  localparam int unsigned NCYC  = AES_NBYTES / LANES;
  localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be one of 1, 2, 4, 8, 16");
  end

  aes_eng_state_e         r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [AES_STATE_W-1:0] r_work;
  logic                   r_out_valid;
  logic [AES_STATE_W-1:0] r_out_state;

  logic [7:0]             w_lane_in  [LANES];
  logic [7:0]             w_lane_out [LANES];
  logic [AES_STATE_W-1:0] w_work_next;
  int unsigned            w_base;

  // First byte index handled this cycle.
  assign w_base = 32'(r_cnt) * LANES;

  // Gather this cycle's bytes and splice their substitutions back in place.
  always_comb begin
    w_work_next = r_work;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_lane_in[i] = r_work[7'(AES_STATE_W - 1 - AES_BYTE_W * (w_base + i)) -: AES_BYTE_W];
      w_work_next[7'(AES_STATE_W - 1 - AES_BYTE_W * (w_base + i)) -: AES_BYTE_W] = w_lane_out[i];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox u_sbox (
      .selector (w_lane_in[g]),
      .out      (w_lane_out[g])
    );
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ENG_IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_out_valid <= 1'b0;
      r_out_state <= '0;
    end else begin
      case (r_state)
        ENG_IDLE: begin
          if (bus.in_valid) begin
            r_work  <= bus.in_state;
            r_cnt   <= '0;
            r_state <= ENG_RUN;
          end
        end
        ENG_RUN: begin
          r_work <= w_work_next;
          if (r_cnt == CNT_W'(NCYC - 1)) begin
            r_out_state <= w_work_next;
            r_out_valid <= 1'b1;
            r_state     <= ENG_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ENG_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ENG_IDLE;
          end
        end
        default: begin
          r_state     <= ENG_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Ready depends only on state and reset, never on in_valid.
  assign bus.in_ready  = (r_state == ENG_IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_state = r_out_state;
  assign bus.busy      = (r_state == ENG_RUN) || (r_state == ENG_DONE);

endmodule : sub_bytes_engine

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine: directed vectors, latency per
// LANES, backpressure, mid-run reset and a random stream against a
// GF(2^8)-based S-box model.
module tb_sub_bytes_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sub_bytes_engine_if m ();
  sub_bytes_engine_if if_l1 ();
  sub_bytes_engine_if if_l2 ();
  sub_bytes_engine_if if_l8 ();
  sub_bytes_engine_if if_l16 ();

  sub_bytes_engine #(.LANES(4))  u_dut (.clk(clk), .rst(rst), .bus(m));
  sub_bytes_engine #(.LANES(1))  u_l1  (.clk(clk), .rst(rst), .bus(if_l1));
  sub_bytes_engine #(.LANES(2))  u_l2  (.clk(clk), .rst(rst), .bus(if_l2));
  sub_bytes_engine #(.LANES(8))  u_l8  (.clk(clk), .rst(rst), .bus(if_l8));
  sub_bytes_engine #(.LANES(16)) u_l16 (.clk(clk), .rst(rst), .bus(if_l16));

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] sb_ref [256];

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int b = 1; b < 256; b++)
      if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sb_ref[s[127 - 8*i -: 8]];
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one block through the LANES=4 engine and drain it.
  task automatic run_block(input string tag, input logic [127:0] din, input logic [127:0] exp);
    int lat;
    chk({tag, "_in_ready"}, 128'(m.in_ready), 128'd1);
    m.in_state = din;
    m.in_valid = 1'b1;
    tick();
    m.in_valid = 1'b0;
    chk({tag, "_busy"}, 128'(m.busy), 128'd1);
    lat = 0;
    while (!m.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'd4);
    chk({tag, "_state"}, m.out_state, exp);
    m.out_ready = 1'b1;
    tick();
    m.out_ready = 1'b0;
    chk({tag, "_valid_clr"}, 128'(m.out_valid), 128'd0);
    chk({tag, "_ready_back"}, 128'(m.in_ready), 128'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, lat1, lat2, lat8, lat16, sent, rcvd;
    logic [127:0] st1, st2, st8, st16, obs;
    logic fire_in, fire_out;
    logic [127:0] q[$];

    for (int a = 0; a < 256; a++) sb_ref[a] = sbox_model(8'(a));

    m.in_valid = 1'b0; m.in_state = '0; m.out_ready = 1'b0;
    if_l1.in_valid = 1'b0;  if_l1.in_state = '0;  if_l1.out_ready = 1'b1;
    if_l2.in_valid = 1'b0;  if_l2.in_state = '0;  if_l2.out_ready = 1'b1;
    if_l8.in_valid = 1'b0;  if_l8.in_state = '0;  if_l8.out_ready = 1'b1;
    if_l16.in_valid = 1'b0; if_l16.in_state = '0; if_l16.out_ready = 1'b1;

    // Reset values
    rst = 1'b1;
    tick(); tick();
    chk("rst_in_ready",  128'(m.in_ready),  128'd0);
    chk("rst_out_valid", 128'(m.out_valid), 128'd0);
    chk("rst_busy",      128'(m.busy),      128'd0);
    chk("rst_out_state", m.out_state,       128'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 128'(m.in_ready), 128'd1);

    // Directed vectors
    run_block("zero",    128'h0, {16{8'h63}});
    run_block("ordered", 128'h000102030405060708090a0b0c0d0e0f,
                         128'h637c777bf26b6fc53001672bfed7ab76);
    run_block("fips4",   FIPS_IN, FIPS_OUT);

    // FIPS vector and latency for the other lane counts
    if_l1.in_state = FIPS_IN; if_l2.in_state = FIPS_IN;
    if_l8.in_state = FIPS_IN; if_l16.in_state = FIPS_IN;
    if_l1.in_valid = 1'b1; if_l2.in_valid = 1'b1; if_l8.in_valid = 1'b1; if_l16.in_valid = 1'b1;
    tick();
    if_l1.in_valid = 1'b0; if_l2.in_valid = 1'b0; if_l8.in_valid = 1'b0; if_l16.in_valid = 1'b0;
    lat1 = 0; lat2 = 0; lat8 = 0; lat16 = 0;
    st1 = '0; st2 = '0; st8 = '0; st16 = '0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (if_l1.out_valid  && lat1  == 0) begin lat1  = t; st1  = if_l1.out_state;  end
      if (if_l2.out_valid  && lat2  == 0) begin lat2  = t; st2  = if_l2.out_state;  end
      if (if_l8.out_valid  && lat8  == 0) begin lat8  = t; st8  = if_l8.out_state;  end
      if (if_l16.out_valid && lat16 == 0) begin lat16 = t; st16 = if_l16.out_state; end
    end
    chk("l1_latency",  128'(lat1),  128'd16);
    chk("l2_latency",  128'(lat2),  128'd8);
    chk("l8_latency",  128'(lat8),  128'd2);
    chk("l16_latency", 128'(lat16), 128'd1);
    chk("l1_state",  st1,  FIPS_OUT);
    chk("l2_state",  st2,  FIPS_OUT);
    chk("l8_state",  st8,  FIPS_OUT);
    chk("l16_state", st16, FIPS_OUT);

    // Output backpressure with an ignored second request
    m.in_state = FIPS_IN;
    m.in_valid = 1'b1;
    tick();
    m.in_valid = 1'b0;
    lat = 0;
    while (!m.out_valid && lat < 40) begin tick(); lat++; end
    chk("bp_latency", 128'(lat), 128'd4);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid_hold", 128'(m.out_valid), 128'd1);
      chk("bp_state_hold", m.out_state, FIPS_OUT);
      chk("bp_in_ready",   128'(m.in_ready), 128'd0);
      if (k == 2) begin m.in_valid = 1'b1; m.in_state = {16{8'hff}}; end
      if (k == 6) m.in_valid = 1'b0;
      tick();
    end
    m.out_ready = 1'b1;
    tick();
    m.out_ready = 1'b0;
    chk("bp_valid_clr", 128'(m.out_valid), 128'd0);
    chk("bp_ready_back", 128'(m.in_ready), 128'd1);
    chk("bp_not_busy",   128'(m.busy),     128'd0);

    // Reset in the middle of RUN
    m.in_state = 128'h0;
    m.in_valid = 1'b1;
    tick();
    m.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", 128'(m.out_valid), 128'd0);
    chk("mrst_busy",      128'(m.busy),      128'd0);
    chk("mrst_out_state", m.out_state,       128'd0);
    chk("mrst_in_ready",  128'(m.in_ready),  128'd1);
    run_block("ones", {16{8'hff}}, {16{8'h16}});

    // Random stream with gaps on both sides
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 20000 && rcvd < 100; cyc++) begin
      if (!m.in_valid && sent < 100 && $urandom_range(0, 2) != 0) begin
        m.in_state = {$urandom, $urandom, $urandom, $urandom};
        m.in_valid = 1'b1;
      end
      m.out_ready = ($urandom_range(0, 3) != 0);
      fire_in  = m.in_valid && m.in_ready;
      fire_out = m.out_valid && m.out_ready;
      obs      = m.out_state;
      tick();
      if (fire_in) begin
        q.push_back(ref_sub(m.in_state));
        sent++;
        m.in_valid = 1'b0;
      end
      if (fire_out) begin
        chk("stream_pending", 128'(q.size()), 128'd1);
        if (q.size() != 0) chk("stream_data", obs, q.pop_front());
        rcvd++;
      end
    end
    m.in_valid = 1'b0;
    m.out_ready = 1'b0;
    chk("stream_sent", 128'(sent), 128'd100);
    chk("stream_rcvd", 128'(rcvd), 128'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_sub_bytes_engine
